// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drains a FIFO read port and shifts each word out as a UART frame.
// Frames chain back-to-back while data remains; o_tx comes straight from a flop.
module fifo_uart_tx #(
    parameter int DSIZE        = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic             i_rempty,
    input  logic [DSIZE-1:0] i_rdata,
    output logic             o_rd,
    output logic             o_tx,
    output logic             o_busy,
    output logic             o_frame_done
);
    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int NW = (DSIZE > 1) ? $clog2(DSIZE) : 1;

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    state_t           state, state_nx;
    logic [BW-1:0]    baud, baud_nx;
    logic [NW-1:0]    bitn, bitn_nx;
    logic             stopn, stopn_nx;
    logic [DSIZE-1:0] sh, sh_nx;
    logic             par, par_nx;
    logic             tx, tx_nx;
    logic             armed;
    logic             baud_end;
    logic             last_stop;
    logic             pop_ok;
    logic             rd;

    assign baud_end  = (baud == BW'(CLKS_PER_BIT - 1));
    assign last_stop = (state == STOP) && baud_end
                    && (stopn == 1'(STOP_BITS - 1));
    assign pop_ok    = i_en & ~i_rempty & armed;
    assign rd        = pop_ok & ((state == IDLE) | last_stop);

    assign o_rd         = rd;
    assign o_tx         = tx;
    assign o_busy       = (state != IDLE);
    assign o_frame_done = last_stop;

    // Hold off pops for one cycle after reset so a stale empty flag is never trusted.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) armed <= 1'b0;
        else          armed <= 1'b1;
    end

    // State, counters, shift register and the line flop.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
            baud  <= '0;
            bitn  <= '0;
            stopn <= 1'b0;
            sh    <= '0;
            par   <= 1'b0;
            tx    <= 1'b1;
        end else begin
            state <= state_nx;
            baud  <= baud_nx;
            bitn  <= bitn_nx;
            stopn <= stopn_nx;
            sh    <= sh_nx;
            par   <= par_nx;
            tx    <= tx_nx;
        end
    end

    // Next-state: walk the frame one bit time at a time; a pop restarts at START.
    always_comb begin
        state_nx = state;
        baud_nx  = baud;
        bitn_nx  = bitn;
        stopn_nx = stopn;
        sh_nx    = sh;
        par_nx   = par;
        tx_nx    = tx;
        if (state != IDLE) begin
            baud_nx = baud_end ? '0 : baud + BW'(1);
        end
        unique case (state)
            IDLE: state_nx = IDLE;
            START: begin
                if (baud_end) begin
                    state_nx = DATA;
                    tx_nx    = sh[0];
                end
            end
            DATA: begin
                if (baud_end) begin
                    sh_nx = sh >> 1;
                    if (bitn == NW'(DSIZE - 1)) begin
                        bitn_nx = '0;
                        if (PARITY != 0) begin
                            state_nx = PAR;
                            tx_nx    = par;
                        end else begin
                            state_nx = STOP;
                            tx_nx    = 1'b1;
                        end
                    end else begin
                        bitn_nx = bitn + NW'(1);
                        tx_nx   = sh[1];
                    end
                end
            end
            PAR: begin
                if (baud_end) begin
                    state_nx = STOP;
                    tx_nx    = 1'b1;
                end
            end
            STOP: begin
                if (last_stop) begin
                    stopn_nx = 1'b0;
                    state_nx = IDLE;
                    tx_nx    = 1'b1;
                end else if (baud_end) begin
                    stopn_nx = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
        if (rd) begin
            state_nx = START;
            sh_nx    = i_rdata;
            par_nx   = (PARITY == 2) ? ~^i_rdata : ^i_rdata;
            tx_nx    = 1'b0;
            baud_nx  = '0;
            bitn_nx  = '0;
            stopn_nx = 1'b0;
        end
    end
endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: three transmitter lanes (no/even/odd parity) fed by queue FIFOs.
// Expected line levels come from a per-cycle frame schedule built from each popped word.
module tb_fifo_uart_tx;
    localparam int CPB = 4;
    localparam int NL  = 3;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       en    = 1'b0;
    logic       rempty [NL];
    logic [7:0] rdata  [NL];
    logic       rd     [NL];
    logic       tx     [NL];
    logic       busy   [NL];
    logic       done   [NL];

    logic [7:0] fifo [NL][$];
    bit         txq  [NL][$];
    bit         pend [NL];
    bit         armed_m = 1'b0;
    int         rd_cnt   [NL] = '{0, 0, 0};
    int         done_cnt [NL] = '{0, 0, 0};
    int         n_cmp = 0;
    int         n_bad = 0;

    always #5 clk = ~clk;

    fifo_uart_tx #(.DSIZE(8), .CLKS_PER_BIT(CPB), .PARITY(0), .STOP_BITS(1)) u0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_rempty(rempty[0]),
        .i_rdata(rdata[0]), .o_rd(rd[0]), .o_tx(tx[0]), .o_busy(busy[0]),
        .o_frame_done(done[0]));
    fifo_uart_tx #(.DSIZE(8), .CLKS_PER_BIT(CPB), .PARITY(1), .STOP_BITS(1)) u1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_rempty(rempty[1]),
        .i_rdata(rdata[1]), .o_rd(rd[1]), .o_tx(tx[1]), .o_busy(busy[1]),
        .o_frame_done(done[1]));
    fifo_uart_tx #(.DSIZE(8), .CLKS_PER_BIT(CPB), .PARITY(2), .STOP_BITS(2)) u2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_rempty(rempty[2]),
        .i_rdata(rdata[2]), .o_rd(rd[2]), .o_tx(tx[2]), .o_busy(busy[2]),
        .o_frame_done(done[2]));

    function automatic int par_of(input int k);
        return k;
    endfunction

    function automatic int stp_of(input int k);
        return (k == 2) ? 2 : 1;
    endfunction

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", tag, got, exp);
        end
    endtask

    task automatic drive();
        for (int k = 0; k < NL; k++) begin
            rempty[k] = (fifo[k].size() == 0);
            rdata[k]  = (fifo[k].size() == 0) ? 8'h00 : fifo[k][0];
        end
    endtask

    task automatic push_all(input logic [7:0] w);
        for (int k = 0; k < NL; k++) fifo[k].push_back(w);
        drive();
    endtask

    task automatic push_rand();
        for (int k = 0; k < NL; k++) fifo[k].push_back(8'($urandom));
        drive();
    endtask

    // Frame = start, 8 data LSB first, optional parity, stop bits; each bit CPB cycles.
    task automatic add_frame(input int k, input logic [7:0] w);
        bit b[$];
        b.push_back(1'b0);
        for (int i = 0; i < 8; i++) b.push_back(w[i]);
        if (par_of(k) == 1) b.push_back(($countones(w) % 2) == 1);
        if (par_of(k) == 2) b.push_back(($countones(w) % 2) == 0);
        for (int s = 0; s < stp_of(k); s++) b.push_back(1'b1);
        foreach (b[i]) repeat (CPB) txq[k].push_back(b[i]);
    endtask

    task automatic step();
        bit   erd;
        bit   etx;
        bit   dummy;
        logic [7:0] wd;
        @(negedge clk);
        for (int k = 0; k < NL; k++) begin
            erd = armed_m && rst_n && en && (fifo[k].size() != 0)
               && (txq[k].size() <= 1);
            etx = (txq[k].size() != 0) ? txq[k][0] : 1'b1;
            chk($sformatf("rd%0d", k), int'(rd[k]), int'(erd));
            chk($sformatf("tx%0d", k), int'(tx[k]), int'(etx));
            chk($sformatf("busy%0d", k), int'(busy[k]), int'(txq[k].size() != 0));
            chk($sformatf("done%0d", k), int'(done[k]), int'(txq[k].size() == 1));
            if (rd[k] === 1'b1) rd_cnt[k]++;
            if (done[k] === 1'b1) done_cnt[k]++;
            if (txq[k].size() != 0) dummy = txq[k].pop_front();
            if (erd) add_frame(k, fifo[k][0]);
            pend[k] = (rd[k] === 1'b1);
        end
        @(posedge clk);
        armed_m = rst_n;
        #1;
        for (int k = 0; k < NL; k++) begin
            if (pend[k] && fifo[k].size() != 0) wd = fifo[k].pop_front();
        end
        drive();
    endtask

    task automatic hit_reset();
        rst_n   = 1'b0;
        armed_m = 1'b0;
        for (int k = 0; k < NL; k++) txq[k].delete();
        #1;
        for (int k = 0; k < NL; k++) begin
            chk($sformatf("arst_tx%0d", k), int'(tx[k]), 1);
            chk($sformatf("arst_busy%0d", k), int'(busy[k]), 0);
            chk($sformatf("arst_rd%0d", k), int'(rd[k]), 0);
        end
    endtask

    initial begin
        int base;
        int dbase;
        drive();
        repeat (3) step();
        chk("rst_tx", int'(tx[0]), 1);
        chk("rst_busy", int'(busy[0]), 0);
        rst_n = 1'b1;
        en    = 1'b1;
        repeat (200) step();
        chk("empty_pops", rd_cnt[0], 0);
        chk("empty_tx", int'(tx[0]), 1);

        push_all(8'hA5);
        repeat (60) step();
        chk("a5_pops", rd_cnt[0], 1);
        chk("a5_done", done_cnt[0], 1);
        chk("a5_busy", int'(busy[0]), 0);

        push_all(8'h01);
        push_all(8'h80);
        push_all(8'hFF);
        repeat (160) step();
        chk("three_pops", rd_cnt[0], 4);
        chk("three_done", done_cnt[0], 4);
        chk("three_done2", done_cnt[2], 4);

        push_all(8'h07);
        repeat (70) step();

        base  = rd_cnt[0];
        dbase = done_cnt[0];
        push_all(8'h11);
        push_all(8'h22);
        push_all(8'h33);
        for (int i = 0; i < 120 && rd_cnt[0] < base + 2; i++) step();
        chk("en_second_pop", rd_cnt[0], base + 2);
        repeat (10) step();
        en = 1'b0;
        repeat (150) step();
        chk("en_left", fifo[0].size(), 1);
        chk("en_pops", rd_cnt[0], base + 2);
        chk("en_done", done_cnt[0], dbase + 2);
        en = 1'b1;
        repeat (200) step();

        base = rd_cnt[0];
        push_all(8'h3C);
        for (int i = 0; i < 20 && rd_cnt[0] == base; i++) step();
        chk("r_pop", rd_cnt[0], base + 1);
        repeat (4 + 3 * CPB) step();
        hit_reset();
        repeat (3) step();
        chk("r_empty", fifo[0].size(), 0);
        push_all(8'h5A);
        base = rd_cnt[0];
        rst_n = 1'b1;
        #1;
        chk("rel_rd_now", int'(rd[0]), 0);
        step();
        chk("rel_c1", rd_cnt[0], base);
        step();
        chk("rel_c2", rd_cnt[0], base + 1);
        repeat (80) step();

        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(59) == 0) push_rand();
            if ($urandom_range(99) == 0) en = ~en;
            step();
        end
        en = 1'b1;
        repeat (400) step();
        for (int k = 0; k < NL; k++) begin
            chk($sformatf("drain%0d", k), fifo[k].size(), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
